// File: rtl/aes_batch_ctrl_if.sv
// AES unit link: key-expansion / start pulses and text out, key-valid / result-valid and ciphertext back.
// Latency: none, wires only.
// Backpressure: none; the AES unit answers each start with exactly one aes_text_val pulse.
// Macro: none.
// Ports: master = batch controller side, slave = AES unit side.
interface aes_batch_ctrl_if;
  logic         aes_key_exp;
  logic         aes_start;
  logic [127:0] aes_text_in;
  logic         aes_key_val;
  logic         aes_text_val;
  logic [127:0] aes_text_out;

  modport master (
    output aes_key_exp, aes_start, aes_text_in,
    input  aes_key_val, aes_text_val, aes_text_out
  );

  modport slave (
    input  aes_key_exp, aes_start, aes_text_in,
    output aes_key_val, aes_text_val, aes_text_out
  );
endinterface

// File: rtl/aes_batch_ctrl.sv
// Batch controller: runs key expansion, then a batch of run_count encryptions separated by gap_cycles idle cycles.
// Latency: first aes_start one cycle after run_req; done two cycles after the last aes_text_val (or after run_req if run_count=0).
// Backpressure: none; key_req/run_req are dropped while busy, and run_req is dropped without valid round keys.
// Macro: AES_BATCH_CHAIN_EN -- when defined, each intermediate ciphertext becomes the next encryption's input.
// Ports: clock/resetn (async active-low); key_req, run_req, run_count, gap_cycles, pt_in from the host;
//        aes (master) to the AES unit; result, done, busy, done_count, trig back to the host.
module aes_batch_ctrl (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    key_req,
  input  logic                    run_req,
  input  logic [15:0]             run_count,
  input  logic [7:0]              gap_cycles,
  input  logic [127:0]            pt_in,
  aes_batch_ctrl_if.master        aes,
  output logic [127:0]            result,
  output logic                    done,
  output logic                    busy,
  output logic [15:0]             done_count,
  output logic                    trig
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    KWAIT  = 3'd2,
    START  = 3'd3,
    EWAIT  = 3'd4,
    GAP    = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  count_q, count_d;
  logic [7:0]   gap_q, gap_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
  logic [127:0] text_q, text_d;
  logic [127:0] result_q, result_d;
  logic [15:0]  done_count_q, done_count_d;
  logic         done_q, done_d;
  logic         trig_q, trig_d;

  logic         key_exp;
  logic         start;
  logic         last_enc;
  logic [15:0]  done_count_inc;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    text_d       = text_q;
    result_d     = result_q;
    done_count_d = done_count_q;
    done_d       = 1'b0;
    key_exp      = 1'b0;
    start        = 1'b0;

    // Saturating increment: the counter stops at 65535 instead of wrapping.
    done_count_inc = (done_count_q == 16'hFFFF) ? done_count_q : done_count_q + 16'd1;
    // Widened compare so the result that would be 65536 can never alias to 0.
    last_enc = (({1'b0, done_count_q} + 17'd1) == {1'b0, count_q});

    case (state_q)
      IDLE: begin
        // key_req has priority; a simultaneous run_req is dropped.
        if (key_req) begin
          state_d = KEYEXP;
        end else if (run_req && aes.aes_key_val) begin
          count_d      = run_count;
          gap_d        = gap_cycles;
          text_d       = pt_in;
          done_count_d = 16'd0;
          state_d      = (run_count == 16'd0) ? FINISH : START;
        end
      end
      KEYEXP: begin
        key_exp = 1'b1;
        state_d = KWAIT;
      end
      KWAIT: begin
        if (aes.aes_key_val) begin
          state_d = IDLE;
        end
      end
      START: begin
        start   = 1'b1;
        state_d = EWAIT;
      end
      EWAIT: begin
        if (aes.aes_text_val) begin
          result_d     = aes.aes_text_out;
          done_count_d = done_count_inc;
          if (last_enc) begin
            state_d = FINISH;
          end else begin
`ifdef AES_BATCH_CHAIN_EN
            text_d = aes.aes_text_out;
`endif
            if (gap_q == 8'd0) begin
              state_d = START;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        // Loaded with gap_cycles on entry, leaves when it reads 1: exactly gap_cycles cycles here.
        if (gap_cnt_q <= 8'd1) begin
          state_d = START;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    trig_d = start;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      count_q      <= 16'd0;
      gap_q        <= 8'd0;
      gap_cnt_q    <= 8'd0;
      text_q       <= 128'd0;
      result_q     <= 128'd0;
      done_count_q <= 16'd0;
      done_q       <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      text_q       <= text_d;
      result_q     <= result_d;
      done_count_q <= done_count_d;
      done_q       <= done_d;
      trig_q       <= trig_d;
    end
  end

  assign aes.aes_key_exp = key_exp;
  assign aes.aes_start   = start;
  assign aes.aes_text_in = text_q;
  assign result          = result_q;
  assign done            = done_q;
  assign busy            = (state_q != IDLE);
  assign done_count      = done_count_q;
  assign trig            = trig_q;

endmodule

// File: tb/tb_aes_batch_ctrl.sv
// Bench for aes_batch_ctrl: behavioural AES unit plus a batch timing and data reference model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_aes_batch_ctrl;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         key_req = 1'b0;
  logic         run_req = 1'b0;
  logic [15:0]  run_count = 16'd0;
  logic [7:0]   gap_cycles = 8'd0;
  logic [127:0] pt_in = 128'd0;
  logic [127:0] result;
  logic         done;
  logic         busy;
  logic [15:0]  done_count;
  logic         trig;

  aes_batch_ctrl_if aes ();

  aes_batch_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_req    (key_req),
    .run_req    (run_req),
    .run_count  (run_count),
    .gap_cycles (gap_cycles),
    .pt_in      (pt_in),
    .aes        (aes),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .done_count (done_count),
    .trig       (trig)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural AES: the FIPS-197 vector maps to its known ciphertext, anything else to a fixed scramble.
  function automatic logic [127:0] aes_model(input logic [127:0] x);
    if (x == FIPS_PT) return FIPS_CT;
    return {x[95:0], x[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  int           lat = 11;
  int           start_cyc[$];
  logic [127:0] start_txt[$];
  int           done_cyc[$];
  int           trig_cyc[$];
  int           kexp_cyc[$];
  bit           resp_pend = 1'b0;
  int           resp_at = 0;
  logic [127:0] resp_txt = 128'd0;
  int           key_at = -1;

  // AES unit model and event logger; runs at the falling edge.
  initial begin
    aes.aes_key_val  = 1'b0;
    aes.aes_text_val = 1'b0;
    aes.aes_text_out = 128'd0;
    forever begin
      @(negedge clock);
      aes.aes_text_val = 1'b0;
      if (done) done_cyc.push_back(cyc);
      if (trig) trig_cyc.push_back(cyc);
      if (aes.aes_start) begin
        start_cyc.push_back(cyc);
        start_txt.push_back(aes.aes_text_in);
      end
      if (!resetn) begin
        resp_pend = 1'b0;
      end else begin
        if (aes.aes_start) begin
          resp_pend = 1'b1;
          resp_at   = cyc + lat;
          resp_txt  = aes.aes_text_in;
        end
        if (resp_pend && cyc == resp_at) begin
          aes.aes_text_val = 1'b1;
          aes.aes_text_out = aes_model(resp_txt);
          resp_pend = 1'b0;
        end
        if (aes.aes_key_exp) begin
          kexp_cyc.push_back(cyc);
          aes.aes_key_val = 1'b0;
          key_at = cyc + 10;
        end
        if (cyc == key_at) aes.aes_key_val = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    start_cyc.delete();
    start_txt.delete();
    done_cyc.delete();
    trig_cyc.delete();
    kexp_cyc.delete();
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ctl"}, 128'({aes.aes_key_exp, aes.aes_start, done, busy, trig}), 128'd0);
    chk({tag, "_txt"}, aes.aes_text_in, 128'd0);
    chk({tag, "_res"}, result, 128'd0);
    chk({tag, "_cnt"}, 128'(done_count), 128'd0);
  endtask

  // Drives one batch and compares against timing/data derived from the batch rules.
  task automatic run_batch(input int n, input int g, input logic [127:0] pt, input string tag);
    int c;
    int sp;
    int budget;
    int i;
    int done_at;
    logic [127:0] t;
    logic [127:0] last_res;
    clear_logs();
    tick();
    run_req = 1'b1; run_count = 16'(n); gap_cycles = 8'(g); pt_in = pt; c = cyc;
    tick();
    run_req = 1'b0; run_count = 16'($urandom); gap_cycles = 8'($urandom);
    pt_in = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    chk({tag, "_dcnt_clr"}, 128'(done_count), 128'd0);
    sp = lat + 1 + g;
    budget = n * sp + 20;
    i = 0;
    while (done_cyc.size() == 0 && i < budget) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk({tag, "_nstart"}, 128'(start_cyc.size()), 128'(n));
    chk({tag, "_ntrig"}, 128'(trig_cyc.size()), 128'(n));
    t = pt;
    last_res = 128'd0;
    for (int k = 0; k < n; k++) begin
      if (k < start_cyc.size()) begin
        chk({tag, "_start_cyc"}, 128'(start_cyc[k]), 128'(c + 1 + k * sp));
        chk({tag, "_text_in"}, start_txt[k], t);
      end
      if (k < trig_cyc.size())
        chk({tag, "_trig_cyc"}, 128'(trig_cyc[k]), 128'(c + 2 + k * sp));
      last_res = aes_model(t);
`ifdef AES_BATCH_CHAIN_EN
      t = last_res;
`else
      t = pt;
`endif
    end
    done_at = (n == 0) ? c + 2 : c + 1 + (n - 1) * sp + lat + 2;
    chk({tag, "_ndone"}, 128'(done_cyc.size()), 128'd1);
    if (done_cyc.size() > 0)
      chk({tag, "_done_cyc"}, 128'(done_cyc[0]), 128'(done_at));
    chk({tag, "_done_count"}, 128'(done_count), 128'(n));
    if (n > 0) chk({tag, "_result"}, result, last_res);
    chk({tag, "_busy_end"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int c;
    int i;
    int n;
    int g;

    // Reset state.
    repeat (3) tick();
    chk_zero_outs("reset");
    resetn = 1'b1;
    tick();

    // Run without round keys: dropped.
    clear_logs();
    run_req = 1'b1; run_count = 16'd3; gap_cycles = 8'd1; pt_in = FIPS_PT;
    tick();
    run_req = 1'b0;
    chk("nokey_busy", 128'(busy), 128'd0);
    repeat (20) tick();
    chk("nokey_starts", 128'(start_cyc.size()), 128'd0);
    chk("nokey_done", 128'(done_cyc.size()), 128'd0);
    chk("nokey_busy_end", 128'(busy), 128'd0);

    // Key expansion.
    clear_logs();
    key_req = 1'b1; c = cyc;
    tick();
    key_req = 1'b0;
    chk("key_busy", 128'(busy), 128'd1);
    i = 0;
    while (!aes.aes_key_val && i < 40) begin
      tick();
      i++;
    end
    chk("key_val_cyc", 128'(cyc), 128'(c + 11));
    chk("key_busy_kwait", 128'(busy), 128'd1);
    tick();
    chk("key_busy_after", 128'(busy), 128'd0);
    chk("key_nexp", 128'(kexp_cyc.size()), 128'd1);
    if (kexp_cyc.size() > 0) chk("key_exp_cyc", 128'(kexp_cyc[0]), 128'(c + 1));

    // key_req and run_req together: key wins.
    clear_logs();
    key_req = 1'b1; run_req = 1'b1; run_count = 16'd2; gap_cycles = 8'd0;
    tick();
    key_req = 1'b0; run_req = 1'b0;
    i = 0;
    while (!aes.aes_key_val && i < 40) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk("both_nexp", 128'(kexp_cyc.size()), 128'd1);
    chk("both_nstart", 128'(start_cyc.size()), 128'd0);
    chk("both_busy", 128'(busy), 128'd0);

    // Directed batches.
    lat = 11;
    run_batch(3, 4, {$urandom, $urandom, $urandom, $urandom}, "basic");
    run_batch(0, 3, {$urandom, $urandom, $urandom, $urandom}, "zero");
    run_batch(1, 0, {$urandom, $urandom, $urandom, $urandom}, "one");
    run_batch(2, 1, FIPS_PT, "chain");
    if (start_txt.size() > 1) begin
`ifdef AES_BATCH_CHAIN_EN
      chk("chain_fips_2nd", start_txt[1], FIPS_CT);
`else
      chk("chain_fips_2nd", start_txt[1], FIPS_PT);
`endif
    end else begin
      chk("chain_fips_nstart", 128'(start_txt.size()), 128'd2);
    end

    // Mid-batch reset during EWAIT of encryption 2 of 5.
    clear_logs();
    run_req = 1'b1; run_count = 16'd5; gap_cycles = 8'd2;
    pt_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    run_req = 1'b0;
    i = 0;
    while (start_cyc.size() < 2 && i < 100) begin
      tick();
      i++;
    end
    chk("mid_reach_enc2", 128'(start_cyc.size()), 128'd2);
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    chk_zero_outs("mid_rst");
    repeat (3) tick();
    resetn = 1'b1;
    repeat (40) tick();
    chk("mid_no_done", 128'(done_cyc.size()), 128'd0);
    chk("mid_nstart", 128'(start_cyc.size()), 128'd2);
    run_batch(2, 3, {$urandom, $urandom, $urandom, $urandom}, "post_rst");

    // Randomized batches.
    for (int r = 0; r < 12; r++) begin
      lat = int'($urandom_range(16, 1));
      n   = int'($urandom_range(5, 0));
      g   = int'($urandom_range(6, 0));
      run_batch(n, g, {$urandom, $urandom, $urandom, $urandom}, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_batch_ctrl.md
AES_BATCH_CTRL -- requirements
Module: aes_batch_ctrl

Interface
REQ-001 The block SHALL have port: clock  input  1  system clock; all logic is rising-edge.
REQ-002 The block SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have port: key_req  input  1  one-cycle request to run AES key expansion.
REQ-004 The block SHALL have port: run_req  input  1  one-cycle request to start a batch of encryptions.
REQ-005 The block SHALL have port: run_count  input  16  number of encryptions in the batch, sampled on run_req.
REQ-006 The block SHALL have port: gap_cycles  input  8  idle cycles between encryptions, sampled on run_req.
REQ-007 The block SHALL have port: pt_in  input  128  initial plaintext, sampled on run_req.
REQ-008 The block SHALL have port: aes_key_exp  output  1  key-expansion pulse to the AES unit.
REQ-009 The block SHALL have port: aes_start  output  1  encryption start pulse to the AES unit.
REQ-010 The block SHALL have port: aes_text_in  output  128  text presented to the AES unit.
REQ-011 The block SHALL have port: aes_key_val  input  1  round keys valid, from the AES unit.
REQ-012 The block SHALL have port: aes_text_val  input  1  result valid pulse, from the AES unit.
REQ-013 The block SHALL have port: aes_text_out  input  128  AES result.
REQ-014 The block SHALL have ports: result (output, 128, last ciphertext); done (output, 1, one-cycle batch-complete pulse); busy (output, 1, controller not IDLE); done_count (output, 16, encryptions completed in the current or last batch); trig (output, 1, scope trigger).

Function
REQ-015 The FSM SHALL have states IDLE, KEYEXP, KWAIT, START, EWAIT, GAP and FINISH.
REQ-016 In IDLE, key_req SHALL move the FSM to KEYEXP; run_req SHALL be honoured only when aes_key_val=1 and SHALL move the FSM to START; if both are asserted in the same cycle, key_req SHALL win and run_req SHALL be dropped.
REQ-017 KEYEXP SHALL assert aes_key_exp for exactly one cycle and then go to KWAIT; KWAIT SHALL return to IDLE on the first cycle that aes_key_val=1.
REQ-018 On run_req, the block SHALL latch run_count, gap_cycles and pt_in into aes_text_in, and SHALL clear done_count.
REQ-019 If run_count=0, the FSM SHALL go directly to FINISH with no aes_start pulse.
REQ-020 START SHALL assert aes_start for exactly one cycle and then go to EWAIT; aes_text_in SHALL be stable from the start pulse until aes_text_val.
REQ-021 In EWAIT, aes_text_val SHALL capture aes_text_out into result and increment done_count (16-bit, no wrap: the maximum is 65535).
REQ-022 On that aes_text_val, the FSM SHALL go to FINISH if done_count+1 equals the latched count; otherwise it SHALL go to GAP, or directly to START when gap_cycles=0.
REQ-023 GAP SHALL last exactly gap_cycles cycles using a down-counter, then go to START.
REQ-024 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE; key_req and run_req SHALL be ignored while busy=1.
REQ-026 trig SHALL equal aes_start delayed one register stage.

Reset
REQ-027 While resetn=0, the FSM SHALL be in IDLE and every output SHALL be 0: aes_key_exp, aes_start, aes_text_in, result, done, busy, done_count and trig.
REQ-028 Reset asserted mid-batch SHALL abort the batch immediately; no done pulse SHALL be produced.

Configuration
REQ-029 With macro AES_BATCH_CHAIN_EN defined, each aes_text_val that does not end the batch SHALL load aes_text_out into aes_text_in, so encryption i+1 encrypts ciphertext i.
REQ-030 Without AES_BATCH_CHAIN_EN, aes_text_in SHALL hold the latched pt_in for every encryption in the batch.

Verification
REQ-031 Key expansion: pulse key_req, model raises aes_key_val 10 cycles later -> exactly one aes_key_exp pulse; busy=1 until aes_key_val, then busy=0.
REQ-032 Run without a key: run_req while aes_key_val=0 -> no aes_start pulse; busy stays 0.
REQ-033 Basic batch: run_count=3, gap_cycles=4, model answers 11 cycles after each start -> 3 aes_start pulses spaced 12+4 cycles apart, done_count=3, one done pulse, trig follows aes_start by 1 cycle.
REQ-034 Chaining: FIPS-197 key 000102..0f, pt 00112233..ff, run_count=2, AES_BATCH_CHAIN_EN defined -> second aes_text_in=69c4e0d86a7b0430d8cdb78070b4c55a; without the macro -> second aes_text_in=00112233..ff.
REQ-035 run_count=0 -> done pulses 2 cycles after run_req with no aes_start; run_count=1, gap_cycles=0 -> FINISH directly after aes_text_val.
REQ-036 Mid-batch reset: resetn=0 during EWAIT of encryption 2 of 5 -> all outputs 0, no done pulse; a new batch after reset behaves normally.
